// File: rtl/div_issue_ctrl.sv
// ---------------------------------------------------------------------------
// div_issue_ctrl
//
// EX-stage controller that drives the multi-cycle divider from the initiator
// side of its start/annul/finish handshake. It latches the DIV/DIVU operands,
// holds them stable for the whole divide, stalls the pipeline until the
// divider finishes, writes remainder/quotient to HI/LO, aborts on a pipeline
// flush and guards against a hung divider with a watchdog.
//
// Optional feature macro: DIV_ZERO_BYPASS_EN
//   When defined, a divide by zero is not sent to the divider; the result
//   HI = dividend, LO = 32'hFFFFFFFF is written on the following cycle.
//
// Parameters:
//   TIMEOUT       max RUN cycles before the watchdog aborts (40..255)
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   div_op_i      valid DIV/DIVU instruction in EX
//   div_signed_i  1 = DIV (signed), 0 = DIVU
//   rs_i, rt_i    dividend, divisor
//   flush_i       pipeline flush, kills the EX instruction
//   stall_o       combinational stall request to the pipeline
//   hi_we_o       one-cycle HI/LO write enable
//   hi_o, lo_o    remainder, quotient
//   err_o         one-cycle pulse on watchdog abort
//   div_start_o   divider start
//   div_annul_o   divider annul
//   div_signed_o  divider signed select
//   div_op1_o     divider dividend
//   div_op2_o     divider divisor
//   div_result_i  {remainder, quotient} from the divider
//   div_finish_i  divider done, held while start is high
// ---------------------------------------------------------------------------
module div_issue_ctrl #(
  parameter int unsigned TIMEOUT = 48
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        div_op_i,
  input  logic        div_signed_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        hi_we_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        err_o,
  output logic        div_start_o,
  output logic        div_annul_o,
  output logic        div_signed_o,
  output logic [31:0] div_op1_o,
  output logic [31:0] div_op2_o,
  input  logic [63:0] div_result_i,
  input  logic        div_finish_i
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE,
    ABORT
  } state_t;

  localparam logic [7:0] LAST_RUN = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  timeoutCnt_q, timeoutCnt_d;
  logic        abortCnt_q, abortCnt_d;
  logic [31:0] op1_q, op1_d;
  logic [31:0] op2_q, op2_d;
  logic        signed_q, signed_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        start_q, start_d;
  logic        hiWe_q, hiWe_d;
  logic        err_q, err_d;
  logic        issue;

  // A new divide may only be issued once the divider has dropped finish
  // from the previous operation.
  assign issue = div_op_i & ~flush_i & ~div_finish_i;

  // Next-state and output decode. Every register holds by default; the
  // one-cycle pulses (write enable, error) default low.
  always_comb begin
    state_d      = state_q;
    timeoutCnt_d = timeoutCnt_q;
    abortCnt_d   = abortCnt_q;
    op1_d        = op1_q;
    op2_d        = op2_q;
    signed_d     = signed_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    start_d      = start_q;
    hiWe_d       = 1'b0;
    err_d        = 1'b0;
    stall_o      = 1'b0;

    case (state_q)
      IDLE: begin
        stall_o = div_op_i & ~flush_i;
        if (issue) begin
          op1_d        = rs_i;
          op2_d        = rt_i;
          signed_d     = div_signed_i;
          start_d      = 1'b1;
          timeoutCnt_d = 8'd0;
          state_d      = RUN;
`ifdef DIV_ZERO_BYPASS_EN
          // Zero divisor: skip the divider and retire on the next cycle.
          if (rt_i == 32'd0) begin
            start_d = 1'b0;
            hi_d    = rs_i;
            lo_d    = 32'hFFFF_FFFF;
            hiWe_d  = 1'b1;
            state_d = DONE;
          end
`endif
        end
      end

      RUN: begin
        stall_o      = 1'b1;
        timeoutCnt_d = timeoutCnt_q + 8'd1;
        // Flush beats finish, and a finish on the last allowed cycle still
        // beats the watchdog.
        if (flush_i) begin
          start_d    = 1'b0;
          abortCnt_d = 1'b0;
          state_d    = ABORT;
        end else if (div_finish_i) begin
          hi_d    = div_result_i[63:32];
          lo_d    = div_result_i[31:0];
          hiWe_d  = 1'b1;
          start_d = 1'b0;
          state_d = DONE;
        end else if (timeoutCnt_q == LAST_RUN) begin
          start_d    = 1'b0;
          err_d      = 1'b1;
          abortCnt_d = 1'b0;
          state_d    = ABORT;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      ABORT: begin
        // Annul is held two cycles so a divider busy in its divide-by-zero
        // path, which ignores annul, is still released.
        abortCnt_d = 1'b1;
        if (abortCnt_q) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      timeoutCnt_q <= 8'd0;
      abortCnt_q   <= 1'b0;
      op1_q        <= 32'd0;
      op2_q        <= 32'd0;
      signed_q     <= 1'b0;
      hi_q         <= 32'd0;
      lo_q         <= 32'd0;
      start_q      <= 1'b0;
      hiWe_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      timeoutCnt_q <= timeoutCnt_d;
      abortCnt_q   <= abortCnt_d;
      op1_q        <= op1_d;
      op2_q        <= op2_d;
      signed_q     <= signed_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      start_q      <= start_d;
      hiWe_q       <= hiWe_d;
      err_q        <= err_d;
    end
  end

  assign hi_we_o      = hiWe_q;
  assign hi_o         = hi_q;
  assign lo_o         = lo_q;
  assign err_o        = err_q;
  assign div_start_o  = start_q;
  assign div_annul_o  = (state_q == ABORT);
  assign div_signed_o = signed_q;
  assign div_op1_o    = op1_q;
  assign div_op2_o    = op2_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_div_issue_ctrl
//
// Self-checking bench for div_issue_ctrl. A behavioural divider answers the
// start/annul/finish handshake with a configurable latency (or hangs), and
// expected HI/LO values come from plain arithmetic on the operands the bench
// applied. Directed scenarios are followed by randomized divides.
// Honours DIV_ZERO_BYPASS_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_div_issue_ctrl;

  localparam int TIMEOUT = 48;

  logic        clk;
  logic        rst;
  logic        div_op_i;
  logic        div_signed_i;
  logic [31:0] rs_i;
  logic [31:0] rt_i;
  logic        flush_i;
  logic        stall_o;
  logic        hi_we_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        err_o;
  logic        div_start_o;
  logic        div_annul_o;
  logic        div_signed_o;
  logic [31:0] div_op1_o;
  logic [31:0] div_op2_o;
  logic [63:0] div_result_i;
  logic        div_finish_i;

  int          checks;
  int          errors;
  int          divLat;
  bit          divHang;
  logic        divBusy;
  int          divLeft;
  logic [31:0] lastHi;
  logic [31:0] lastLo;

  div_issue_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .div_op_i    (div_op_i),
    .div_signed_i(div_signed_i),
    .rs_i        (rs_i),
    .rt_i        (rt_i),
    .flush_i     (flush_i),
    .stall_o     (stall_o),
    .hi_we_o     (hi_we_o),
    .hi_o        (hi_o),
    .lo_o        (lo_o),
    .err_o       (err_o),
    .div_start_o (div_start_o),
    .div_annul_o (div_annul_o),
    .div_signed_o(div_signed_o),
    .div_op1_o   (div_op1_o),
    .div_op2_o   (div_op2_o),
    .div_result_i(div_result_i),
    .div_finish_i(div_finish_i)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference arithmetic: {remainder, quotient}; divide by zero gives zero,
  // as the real divider does.
  function automatic logic [63:0] refDiv(input logic sgn, input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [31:0] sa, sb, sq, sr;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
      sa = a;
      sb = b;
      sq = sa / sb;
      sr = sa % sb;
      return {sr, sq};
    end
    return {a % b, a / b};
  endfunction

  // Behavioural divider: starts when it sees start, counts divLat cycles,
  // then raises finish with the result computed from the operands it sees at
  // that moment, and holds finish until start drops. Annul or a dropped start
  // clears it. divHang keeps it busy forever.
  always @(posedge clk) begin
    if (rst) begin
      divBusy      <= 1'b0;
      divLeft      <= 0;
      div_finish_i <= 1'b0;
      div_result_i <= 64'd0;
    end else if (!div_start_o || div_annul_o) begin
      divBusy      <= 1'b0;
      div_finish_i <= 1'b0;
    end else if (divBusy) begin
      if (divLeft == 0) begin
        if (!divHang) begin
          divBusy      <= 1'b0;
          div_finish_i <= 1'b1;
          div_result_i <= refDiv(div_signed_o, div_op1_o, div_op2_o);
        end
      end else begin
        divLeft <= divLeft - 1;
      end
    end else if (!div_finish_i) begin
      divBusy <= 1'b1;
      divLeft <= divLat;
    end
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Idle cycles with no instruction in EX.
  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      div_op_i = 1'b0;
      flush_i  = 1'b0;
      #1;
      checkOutput("idleStall", stall_o, 1'b0);
      checkOutput("idleWe", hi_we_o, 1'b0);
    end
  endtask

  // Two annul cycles, then a quiet IDLE cycle; HI/LO must not change.
  task automatic expectAbort(input bit isErr);
    @(negedge clk);
    flush_i  = 1'b0;
    div_op_i = 1'b1;
    #1;
    checkOutput("abortAnnul1", div_annul_o, 1'b1);
    checkOutput("abortErr1", err_o, isErr);
    checkOutput("abortStart1", div_start_o, 1'b0);
    checkOutput("abortStall1", stall_o, 1'b0);
    checkOutput("abortWe1", hi_we_o, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("abortAnnul2", div_annul_o, 1'b1);
    checkOutput("abortErr2", err_o, 1'b0);
    checkOutput("abortStall2", stall_o, 1'b0);
    checkOutput("abortWe2", hi_we_o, 1'b0);
    @(negedge clk);
    div_op_i = 1'b0;
    #1;
    checkOutput("abortAnnulEnd", div_annul_o, 1'b0);
    checkOutput("abortStartEnd", div_start_o, 1'b0);
    checkOutput("abortHiHold", hi_o, lastHi);
    checkOutput("abortLoHold", lo_o, lastLo);
  endtask

  // One DIV/DIVU from issue to retirement or abort. flushAt < 0 means no
  // flush; otherwise flush is raised on that RUN cycle. While running, the
  // EX-side operand inputs are scrambled to prove the latched copies are used.
  task automatic applyStimulus(input logic sgn, input logic [31:0] rs,
                               input logic [31:0] rt, input int flushAt,
                               input bit hang);
    logic [63:0] expected;
    bit          finished;
    int          k;
    expected = refDiv(sgn, rs, rt);
    divHang  = hang;
    @(negedge clk);
    div_op_i     = 1'b1;
    div_signed_i = sgn;
    rs_i         = rs;
    rt_i         = rt;
    flush_i      = 1'b0;
    #1;
    checkOutput("issueStall", stall_o, 1'b1);
    checkOutput("issueNoStart", div_start_o, 1'b0);
`ifdef DIV_ZERO_BYPASS_EN
    if (rt == 32'd0) begin
      @(negedge clk);
      #1;
      checkOutput("bypassWe", hi_we_o, 1'b1);
      checkOutput("bypassHi", hi_o, rs);
      checkOutput("bypassLo", lo_o, 32'hFFFF_FFFF);
      checkOutput("bypassStart", div_start_o, 1'b0);
      checkOutput("bypassStall", stall_o, 1'b0);
      lastHi = rs;
      lastLo = 32'hFFFF_FFFF;
      return;
    end
`endif
    finished = 1'b0;
    k        = 0;
    while (!finished) begin
      @(negedge clk);
      rs_i         = $urandom;
      rt_i         = $urandom;
      div_signed_i = 1'($urandom_range(0, 1));
      flush_i      = (k == flushAt);
      #1;
      checkOutput("runStall", stall_o, 1'b1);
      checkOutput("runStart", div_start_o, 1'b1);
      checkOutput("runOp1", div_op1_o, rs);
      checkOutput("runOp2", div_op2_o, rt);
      checkOutput("runSigned", div_signed_o, sgn);
      checkOutput("runWe", hi_we_o, 1'b0);
      if (flush_i) begin
        expectAbort(1'b0);
        finished = 1'b1;
      end else if (div_finish_i) begin
        @(negedge clk);
        #1;
        checkOutput("doneWe", hi_we_o, 1'b1);
        checkOutput("doneHi", hi_o, expected[63:32]);
        checkOutput("doneLo", lo_o, expected[31:0]);
        checkOutput("doneStart", div_start_o, 1'b0);
        checkOutput("doneStall", stall_o, 1'b0);
        lastHi   = expected[63:32];
        lastLo   = expected[31:0];
        finished = 1'b1;
      end else if (k == TIMEOUT - 1) begin
        if (hang) begin
          expectAbort(1'b1);
        end else begin
          checkOutput("finishBeforeTimeout", div_finish_i, 1'b1);
        end
        finished = 1'b1;
      end
      k++;
    end
    flush_i = 1'b0;
  endtask

  initial begin
    logic        sgn;
    logic [31:0] rs;
    logic [31:0] rt;
    int          fl;
    checks       = 0;
    errors       = 0;
    divLat       = 32;
    divHang      = 1'b0;
    lastHi       = 32'd0;
    lastLo       = 32'd0;
    rst          = 1'b1;
    div_op_i     = 1'b0;
    div_signed_i = 1'b0;
    rs_i         = 32'd0;
    rt_i         = 32'd0;
    flush_i      = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    checkOutput("rstStart", div_start_o, 1'b0);
    checkOutput("rstAnnul", div_annul_o, 1'b0);
    checkOutput("rstWe", hi_we_o, 1'b0);
    checkOutput("rstErr", err_o, 1'b0);
    checkOutput("rstHi", hi_o, 32'd0);
    checkOutput("rstLo", lo_o, 32'd0);
    checkOutput("rstStall", stall_o, 1'b0);
    rst = 1'b0;
    idleCycles(2);

    $display("[TB] directed divides");
    applyStimulus(1'b0, 32'd100, 32'd7, -1, 1'b0);
    idleCycles(2);
    applyStimulus(1'b1, 32'hFFFF_FFF9, 32'd2, -1, 1'b0);
    idleCycles(1);
    applyStimulus(1'b0, 32'd1000, 32'd10, 10, 1'b0);
    applyStimulus(1'b0, 32'd9, 32'd4, -1, 1'b0);
    idleCycles(1);
    applyStimulus(1'b0, 32'd50, 32'd5, -1, 1'b0);
    applyStimulus(1'b0, 32'd7, 32'd3, -1, 1'b0);
    idleCycles(1);

    $display("[TB] watchdog and divide by zero");
    applyStimulus(1'b0, 32'd123, 32'd4, -1, 1'b1);
    idleCycles(1);
    applyStimulus(1'b0, 32'd5, 32'd0, -1, 1'b0);
    idleCycles(1);

    // A flushed instruction in IDLE must neither stall nor issue.
    @(negedge clk);
    div_op_i = 1'b1;
    flush_i  = 1'b1;
    rs_i     = 32'd20;
    rt_i     = 32'd3;
    #1;
    checkOutput("flushIdleStall", stall_o, 1'b0);
    @(negedge clk);
    div_op_i = 1'b0;
    flush_i  = 1'b0;
    #1;
    checkOutput("flushIdleNoStart", div_start_o, 1'b0);

    $display("[TB] randomized divides");
    for (int n = 0; n < 14; n++) begin
      divLat = $urandom_range(1, 40);
      sgn    = 1'($urandom_range(0, 1));
      rs     = $urandom;
      rt     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      if (sgn && rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF) rt = 32'd3;
      fl     = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : -1;
      applyStimulus(sgn, rs, rt, fl, 1'b0);
      if ($urandom_range(0, 1) == 1) idleCycles($urandom_range(1, 3));
    end
    idleCycles(1);

    // Reset in the middle of a divide returns to IDLE with cleared outputs.
    divLat = 32;
    @(negedge clk);
    div_op_i     = 1'b1;
    div_signed_i = 1'b0;
    rs_i         = 32'd77;
    rt_i         = 32'd3;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    div_op_i = 1'b0;
    #1;
    checkOutput("midRstStart", div_start_o, 1'b0);
    checkOutput("midRstAnnul", div_annul_o, 1'b0);
    checkOutput("midRstStall", stall_o, 1'b0);
    checkOutput("midRstHi", hi_o, 32'd0);
    checkOutput("midRstLo", lo_o, 32'd0);
    lastHi = 32'd0;
    lastLo = 32'd0;
    idleCycles(2);
    applyStimulus(1'b0, 32'd9, 32'd4, -1, 1'b0);
    idleCycles(1);

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
- EX-stage controller that drives the multi-cycle divider from the initiator side of its start/annul/finish handshake.
- Latches the DIV/DIVU operands, holds them stable for the whole operation and stalls the pipeline until the divider finishes.
- Writes quotient/remainder to HI/LO, aborts on pipeline flush and guards against a hung divider with a watchdog.

Parameters:
- TIMEOUT, 48: max cycles in RUN before the watchdog aborts; range 40..255.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- div_op_i  in  1  valid DIV/DIVU instruction present in EX.
- div_signed_i  in  1  1 = DIV (signed), 0 = DIVU.
- rs_i  in  32  dividend.
- rt_i  in  32  divisor.
- flush_i  in  1  pipeline flush; kills the EX instruction.
- stall_o  out  1  combinational stall request to the pipeline.
- hi_we_o  out  1  one-cycle HI/LO write enable.
- hi_o  out  32  remainder.
- lo_o  out  32  quotient.
- err_o  out  1  one-cycle pulse on watchdog abort.
- div_start_o  out  1  divider start.
- div_annul_o  out  1  divider annul.
- div_signed_o  out  1  divider signed select.
- div_op1_o  out  32  divider dividend.
- div_op2_o  out  32  divider divisor.
- div_result_i  in  64  {remainder[63:32], quotient[31:0]}.
- div_finish_i  in  1  divider done; holds while start is high.

Behaviour:
- Reset values: all registered outputs 0, state IDLE, timeout counter 0. Reset mid-operation returns to IDLE without annul; the divider shares rst.
- States: IDLE, RUN, DONE, ABORT.
- IDLE:
  - If div_op_i & !flush_i & !div_finish_i: latch rs_i, rt_i and div_signed_i into op registers, assert div_start_o (registered), go RUN.
  - stall_o = div_op_i & !flush_i in this cycle.
  - flush_i with div_op_i: no issue, no stall.
- RUN:
  - div_start_o = 1; div_op1_o, div_op2_o and div_signed_o come from the latched registers and stay stable, because the divider re-reads operand signs at the end.
  - stall_o = 1. Counter increments each cycle.
  - div_finish_i = 1: capture hi_o <= div_result_i[63:32] and lo_o <= div_result_i[31:0], go DONE.
  - flush_i = 1 (priority over finish): go ABORT, no write.
  - Counter reaches TIMEOUT-1 with no finish: go ABORT, err_o = 1 for the next cycle.
- DONE (exactly 1 cycle):
  - hi_we_o = 1, div_start_o = 0, stall_o = 0 so the instruction retires this cycle. Go IDLE.
  - The divider drops finish on this edge, so IDLE may issue again on the next cycle. Back-to-back divides therefore have 1 idle cycle between them.
- ABORT (exactly 2 cycles, 1-bit counter):
  - div_annul_o = 1, div_start_o = 0, stall_o = 0, hi_we_o = 0. Then IDLE.
  - Two cycles covers a divider sitting in its divide-by-zero path, which ignores annul.
- Latency: issue cycle + divider latency (about 34 cycles) + DONE. stall_o is high from the issue cycle through the last RUN cycle.
- Signed handling is entirely the divider's job; the controller passes div_signed_i through unmodified.
- hi_o/lo_o hold their last written value between operations.

Optional Feature:
- Macro DIV_ZERO_BYPASS_EN.
- Defined: in IDLE, if issuing with rt_i == 0, the divider is not started. Go directly to DONE with hi_o = rs_i and lo_o = 32'hFFFFFFFF. stall_o is high only in the issue cycle.
- Undefined: divisor 0 is issued normally; the divider's zero result (HI = 0, LO = 0) is written.

Test Plan:
- DIVU rs=100, rt=7 -> stall about 35 cycles; a single hi_we_o pulse with hi_o=2, lo_o=14; div_start_o low in DONE.
- DIV rs=32'hFFFFFFF9 (-7), rt=2 -> lo_o=32'hFFFFFFFD (-3), hi_o=32'hFFFFFFFF (-1); div_signed_o=1 throughout RUN.
- DIVU 1000/10, flush_i pulsed on RUN cycle 10 -> div_annul_o high 2 cycles, no hi_we_o, stall_o low after flush; a following DIVU 9/4 gives hi=1, lo=2.
- Two back-to-back DIVU (50/5, then 7/3) -> first write hi=0, lo=10; exactly one idle cycle; second write hi=1, lo=2.
- Divider model that never asserts finish, TIMEOUT=48 -> err_o pulse after 48 RUN cycles, annul 2 cycles, return to IDLE, no write.
- rt=0, rs=5: with DIV_ZERO_BYPASS_EN -> no div_start_o, hi=5, lo=32'hFFFFFFFF next cycle; without -> hi=0, lo=0 after divider completes.
